// File: rtl/bram18k_sdp_fifo.sv
// Synchronous FIFO on a simple-dual-port array sized to map onto a single 18K block RAM.
// Latency: standard mode data appears the edge a read is accepted; FWFT head appears 2 edges after a write into empty.
// Backpressure: writes while FULL_o and reads while EMPTY_o are dropped and flagged by OVERFLOW_o/UNDERFLOW_o pulses.
module bram18k_sdp_fifo #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clock0,
    input  logic                  RESET_ni,
    input  logic                  WEN_i,
    input  logic [DATA_WIDTH-1:0] WDATA_i,
    input  logic                  REN_i,
    output logic [DATA_WIDTH-1:0] RDATA_o,
    output logic                  RVALID_o,
    output logic                  FULL_o,
    output logic                  EMPTY_o,
    output logic                  ALMOST_FULL_o,
    output logic                  ALMOST_EMPTY_o,
    output logic [ADDR_WIDTH:0]   COUNT_o,
    output logic                  OVERFLOW_o,
    output logic                  UNDERFLOW_o
);

    localparam int                DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_nxt;
    logic                wr_acc;
    logic                rd_acc;
    logic                rd_adv;
    logic                arr_empty;
    logic                out_vld;
    logic                out_vld_nxt;
    logic                rvalid_q;

    always_comb begin
        wr_acc      = WEN_i && !FULL_o;
        rd_acc      = REN_i && !EMPTY_o;
        arr_empty   = (wr_ptr == rd_ptr);
        rd_adv      = rd_acc;
        out_vld_nxt = 1'b0;
        if (FWFT != 0) begin
            // Refill the output register when it is empty or being popped this edge.
            rd_adv      = !arr_empty && (!out_vld || rd_acc);
            out_vld_nxt = rd_adv || (out_vld && !rd_acc);
        end
        count_nxt = COUNT_o;
        if (wr_acc && !rd_acc) begin
            count_nxt = COUNT_o + ONE;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = COUNT_o - ONE;
        end
    end

    // Array has no reset so it stays inferable as block RAM.
    always_ff @(posedge clock0) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= WDATA_i;
        end
    end

    always_ff @(posedge clock0 or negedge RESET_ni) begin
        if (!RESET_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            COUNT_o        <= '0;
            RDATA_o        <= '0;
            rvalid_q       <= 1'b0;
            out_vld        <= 1'b0;
            FULL_o         <= 1'b0;
            EMPTY_o        <= 1'b1;
            ALMOST_FULL_o  <= (AF_LEVEL <= 0);
            ALMOST_EMPTY_o <= 1'b1;
            OVERFLOW_o     <= 1'b0;
            UNDERFLOW_o    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_adv) begin
                rd_ptr  <= rd_ptr + ONE;
                RDATA_o <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            rvalid_q       <= rd_acc;
            out_vld        <= out_vld_nxt;
            COUNT_o        <= count_nxt;
            FULL_o         <= (count_nxt == DEPTH_CNT);
            EMPTY_o        <= (FWFT != 0) ? !out_vld_nxt : (count_nxt == '0);
            ALMOST_FULL_o  <= (int'(count_nxt) >= AF_LEVEL);
            ALMOST_EMPTY_o <= (int'(count_nxt) <= AE_LEVEL);
            OVERFLOW_o     <= WEN_i && FULL_o;
            UNDERFLOW_o    <= REN_i && EMPTY_o;
        end
    end

    assign RVALID_o = (FWFT != 0) ? !EMPTY_o : rvalid_q;

endmodule

// File: tb/tb_bram18k_sdp_fifo.sv
// Bench for bram18k_sdp_fifo: standard and FWFT instances share stimulus, each checked against a queue scoreboard.
module tb_bram18k_sdp_fifo;

    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] s_rdata, f_rdata;
    logic          s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic          f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [AW:0]   s_count, f_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] s_q[$];
    logic [DW-1:0] f_q[$];
    logic [DW-1:0] s_last = '0;
    logic          f_vld  = 1'b0;

    always #5 clk = ~clk;

    bram18k_sdp_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_std (
        .clock0(clk), .RESET_ni(rst_n), .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren),
        .RDATA_o(s_rdata), .RVALID_o(s_rvalid), .FULL_o(s_full), .EMPTY_o(s_empty),
        .ALMOST_FULL_o(s_af), .ALMOST_EMPTY_o(s_ae), .COUNT_o(s_count),
        .OVERFLOW_o(s_ovf), .UNDERFLOW_o(s_udf)
    );

    bram18k_sdp_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
        .clock0(clk), .RESET_ni(rst_n), .WEN_i(wen), .WDATA_i(wdata), .REN_i(ren),
        .RDATA_o(f_rdata), .RVALID_o(f_rvalid), .FULL_o(f_full), .EMPTY_o(f_empty),
        .ALMOST_FULL_o(f_af), .ALMOST_EMPTY_o(f_ae), .COUNT_o(f_count),
        .OVERFLOW_o(f_ovf), .UNDERFLOW_o(f_udf)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " s_count"}, 32'(s_count), 0);
        chk({tag, " s_rdata"}, 32'(s_rdata), 0);
        chk({tag, " s_rvalid"}, 32'(s_rvalid), 0);
        chk({tag, " s_full"}, 32'(s_full), 0);
        chk({tag, " s_empty"}, 32'(s_empty), 1);
        chk({tag, " s_ae"}, 32'(s_ae), 1);
        chk({tag, " s_ovf"}, 32'(s_ovf), 0);
        chk({tag, " s_udf"}, 32'(s_udf), 0);
        chk({tag, " f_count"}, 32'(f_count), 0);
        chk({tag, " f_rdata"}, 32'(f_rdata), 0);
        chk({tag, " f_rvalid"}, 32'(f_rvalid), 0);
        chk({tag, " f_empty"}, 32'(f_empty), 1);
        chk({tag, " f_ae"}, 32'(f_ae), 1);
    endtask

    // One clock of stimulus; expectations are derived from the bench queues before the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        int   s_n, f_n, f_arr;
        logic s_acc_r, s_ovf_e, s_udf_e;
        logic f_pop, f_ovf_e, f_udf_e;
        wen   = w;
        wdata = d;
        ren   = r;
        s_n     = s_q.size();
        s_acc_r = r && (s_n != 0);
        s_ovf_e = w && (s_n == DEPTH);
        s_udf_e = r && (s_n == 0);
        if (s_acc_r) s_last = s_q.pop_front();
        if (w && s_n != DEPTH) s_q.push_back(d);
        f_n     = f_q.size();
        f_arr   = f_n - (f_vld ? 1 : 0);
        f_pop   = r && f_vld;
        f_ovf_e = w && (f_n == DEPTH);
        f_udf_e = r && !f_vld;
        if (f_pop) void'(f_q.pop_front());
        if (w && f_n != DEPTH) f_q.push_back(d);
        f_vld = (f_arr > 0) || (f_vld && !f_pop);
        @(posedge clk);
        #1;
        chk("s_count", 32'(s_count), s_q.size());
        chk("s_full", 32'(s_full), 32'(s_q.size() == DEPTH));
        chk("s_empty", 32'(s_empty), 32'(s_q.size() == 0));
        chk("s_af", 32'(s_af), 32'(s_q.size() >= 12));
        chk("s_ae", 32'(s_ae), 32'(s_q.size() <= 4));
        chk("s_ovf", 32'(s_ovf), 32'(s_ovf_e));
        chk("s_udf", 32'(s_udf), 32'(s_udf_e));
        chk("s_rvalid", 32'(s_rvalid), 32'(s_acc_r));
        chk("s_rdata", 32'(s_rdata), 32'(s_last));
        chk("f_count", 32'(f_count), f_q.size());
        chk("f_full", 32'(f_full), 32'(f_q.size() == DEPTH));
        chk("f_empty", 32'(f_empty), 32'(!f_vld));
        chk("f_rvalid", 32'(f_rvalid), 32'(f_vld));
        chk("f_af", 32'(f_af), 32'(f_q.size() >= 12));
        chk("f_ae", 32'(f_ae), 32'(f_q.size() <= 4));
        chk("f_ovf", 32'(f_ovf), 32'(f_ovf_e));
        chk("f_udf", 32'(f_udf), 32'(f_udf_e));
        if (f_vld) chk("f_rdata", 32'(f_rdata), 32'(f_q[0]));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        rst_n = 1'b1;

        // Fill, overflow, drain in order, underflow.
        for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0);
        chk("fill s_full", 32'(s_full), 1);
        chk("fill s_af", 32'(s_af), 1);
        cyc(1'b1, DW'(17), 1'b0);
        chk("ovf s_count", 32'(s_count), 16);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("drain s_rdata", 32'(s_rdata), i);
        end
        chk("drain s_empty", 32'(s_empty), 1);
        cyc(1'b0, '0, 1'b1);
        chk("extra s_udf", 32'(s_udf), 1);
        cyc(1'b0, '0, 1'b0);

        // FWFT head appears two edges after a write into empty.
        cyc(1'b1, 18'h2AAAA, 1'b0);
        chk("fwft e1 empty", 32'(f_empty), 1);
        cyc(1'b0, '0, 1'b0);
        chk("fwft e2 empty", 32'(f_empty), 0);
        chk("fwft e2 rdata", 32'(f_rdata), 32'h2AAAA);
        cyc(1'b0, '0, 1'b1);
        chk("fwft pop empty", 32'(f_empty), 1);
        cyc(1'b0, '0, 1'b0);

        // Simultaneous read/write at full and at empty.
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(32'h100 + i), 1'b0);
        cyc(1'b1, 18'h3FFFF, 1'b1);
        chk("full rw s_count", 32'(s_count), 15);
        chk("full rw f_ovf", 32'(f_ovf), 1);
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 18'h00155, 1'b1);
        chk("empty rw s_count", 32'(s_count), 1);
        chk("empty rw s_udf", 32'(s_udf), 1);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("empty rw s_rdata", 32'(s_rdata), 32'h155);
        cyc(1'b0, '0, 1'b0);

        // Pointer wrap: many write/read pairs.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, DW'(32'h200 + i), 1'b0);
            cyc(1'b0, '0, 1'b0);
            cyc(1'b0, '0, 1'b1);
            chk("wrap s_count bound", 32'(s_count <= 2), 1);
        end

        // Reset mid-operation with a read pending.
        for (int i = 0; i < 7; i++) cyc(1'b1, DW'(32'h700 + i), 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("pre-rst s_count", 32'(s_count), 7);
        wen = 1'b0;
        ren = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        s_q.delete();
        f_q.delete();
        s_last = '0;
        f_vld  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("held");
        ren   = 1'b0;
        rst_n = 1'b1;
        cyc(1'b1, 18'h12345, 1'b0);
        chk("post-rst s_count", 32'(s_count), 1);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("post-rst s_rdata", 32'(s_rdata), 32'h12345);
        chk("post-rst s_rvalid", 32'(s_rvalid), 1);
        cyc(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram18k_sdp_fifo.md
BRAM18K_SDP_FIFO -- requirements
Module: bram18k_sdp_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, word width; legal values 1..36.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal values 4..11.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold.
REQ-005 SHALL have parameter FWFT, default 0; 0 = standard read mode, 1 = first-word-fall-through.
REQ-006 SHALL operate on one clock with asynchronous, active-low reset.
REQ-007 clock0  in  1  sole clock; all state updates on its rising edge.
REQ-008 RESET_ni  in  1  asynchronous active-low reset.
REQ-009 WEN_i  in  1  write request.
REQ-010 WDATA_i  in  DATA_WIDTH  write data.
REQ-011 REN_i  in  1  read request (FWFT: pop).
REQ-012 RDATA_o  out  DATA_WIDTH  read data, registered.
REQ-013 RVALID_o  out  1  standard mode: RDATA_o newly loaded; FWFT: tied to !EMPTY_o.
REQ-014 FULL_o, EMPTY_o  out  1 each  registered status flags.
REQ-015 ALMOST_FULL_o, ALMOST_EMPTY_o  out  1 each  registered threshold flags.
REQ-016 COUNT_o  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-017 OVERFLOW_o, UNDERFLOW_o  out  1 each  one-cycle error pulses.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_WIDTH simple-dual-port array: one write port, one synchronous read port, inferable as one 18K BRAM for DEPTH*DATA_WIDTH <= 18432.
REQ-019 Write and read pointers SHALL be ADDR_WIDTH+1 bits; they wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
REQ-020 A write is accepted iff WEN_i=1 and FULL_o=0; the word is stored at wr_ptr and the pointer increments.
REQ-021 Standard mode: a read is accepted iff REN_i=1 and EMPTY_o=0.
REQ-022 Standard mode: RDATA_o updates one edge after the accepting edge, with RVALID_o=1 for exactly that cycle; otherwise RDATA_o holds.
REQ-023 FWFT mode: an internal prefetch loads the head word into RDATA_o whenever the output register is empty and the array is non-empty.
REQ-024 FWFT mode: EMPTY_o=0 means RDATA_o is valid; a read is accepted iff REN_i=1 and EMPTY_o=0, and the next word (if any) is presented without a bubble.
REQ-025 FWFT mode: COUNT_o includes the word held in the output register.
REQ-026 COUNT_o: +1 on an accepted write only, -1 on an accepted read only, unchanged when both are accepted.
REQ-027 Flags SHALL reflect post-edge COUNT_o:
- FULL_o = (COUNT_o == DEPTH)
- EMPTY_o = (COUNT_o == 0); in FWFT, EMPTY_o = output register invalid
- ALMOST_FULL_o = (COUNT_o >= AF_LEVEL)
- ALMOST_EMPTY_o = (COUNT_o <= AE_LEVEL)
REQ-028 Latency from a write into an empty FIFO: EMPTY_o deasserts after edge N+1 in standard mode and after edge N+2 in FWFT mode.
REQ-029 Simultaneous read and write when full: the read is accepted and the write is rejected, giving OVERFLOW_o=1.
REQ-030 Simultaneous read and write when empty: the write is accepted and the read is rejected, giving UNDERFLOW_o=1.
REQ-031 OVERFLOW_o SHALL pulse one cycle for every WEN_i=1 with FULL_o=1; UNDERFLOW_o likewise for REN_i=1 with EMPTY_o=1.
REQ-032 Rejected operations SHALL change no pointer, count or data.
REQ-033 Pointer wrap SHALL be seamless: data order is preserved across any number of wraps.

Reset
REQ-034 RESET_ni=0 SHALL immediately clear pointers, COUNT_o, RDATA_o, RVALID_o, FULL_o, OVERFLOW_o and UNDERFLOW_o, and set EMPTY_o=1 and ALMOST_EMPTY_o=1.
REQ-035 Array contents SHALL NOT be reset.
REQ-036 Reset asserted mid-operation SHALL abort any pending read or prefetch; no RVALID_o pulse follows.
REQ-037 RESET_ni deassertion is synchronous to clock0, supplied by the system reset synchroniser; the first operation is accepted on the first edge after release.

Verification
REQ-038 Bench SHALL cover the following directed scenarios (DATA_WIDTH=18, ADDR_WIDTH=4, AF_LEVEL=12, AE_LEVEL=4):
- Standard mode: write 0x00001..0x00010 (16 words) -> FULL_o=1, COUNT_o=16, ALMOST_FULL_o=1 from count 12; 17th write -> OVERFLOW_o pulse, count stays 16.
- Standard mode: read 16 words -> RDATA_o sequence 0x00001..0x00010, each one cycle after REN_i with RVALID_o; then EMPTY_o=1; an extra read -> UNDERFLOW_o pulse.
- FWFT mode: single write 0x2AAAA into an empty FIFO -> RDATA_o=0x2AAAA and EMPTY_o=0 two edges later, with REN_i never asserted; pop -> EMPTY_o=1.
- Simultaneous: full plus WEN_i=REN_i=1 -> count 15, OVERFLOW_o=1; empty plus both -> count 1, UNDERFLOW_o=1.
- Wrap: 40 interleaved write/read pairs of an incrementing pattern -> in-order data, count bounded 0..2, no error pulses.
- Reset: assert RESET_ni low with count 7 and a read pending -> all outputs at reset values within the same cycle, no RVALID_o; after release, write 0x12345 then read -> 0x12345.
